serial_addsub: RTL and testbench



---
 rtl/serial_addsub.sv | 131 +++++++++++++
 tb/tb_serial_addsub.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_addsub : bit-serial two's-complement add/subtract, LSB first       |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             w_bx;
  logic             w_sum;
  logic             w_cnext;
  logic             w_last;
  logic [WIDTH-1:0] w_r_next;

  // Single add/sub cell: subtract is a + ~b + 1, the +1 coming from the seeded carry.
  assign w_bx     = b_sh_q[0] ^ mode_q;
  assign w_sum    = a_sh_q[0] ^ w_bx ^ carry_q;
  assign w_cnext  = (a_sh_q[0] & w_bx) | (a_sh_q[0] & carry_q) | (w_bx & carry_q);
  assign w_last   = (cnt_q == LAST_BIT);
  assign w_r_next = {w_sum, r_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    result_d = result_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        r_sh_d  = w_r_next;
        carry_d = w_cnext;
        if (w_last) begin
          // carry_q is the carry into the MSB at this point.
          result_d = w_r_next;
          cout_d   = w_cnext;
          ovf_d    = carry_q ^ w_cnext;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          mode_d  = mode;
          carry_d = mode;
          cnt_d   = '0;
          r_sh_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      result_q <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_addsub : scoreboard bench, directed WIDTH=8 plus random 2/16    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_serial_addsub;

  typedef struct {
    logic [31:0] res;
    bit          c;
    bit          v;
    longint      acc;
  } exp_t;

  logic clk;
  logic rst8_n, rstx_n;
  longint cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0;

  logic start8, m8, busy8, done8, c8, v8;
  logic [7:0] a8, b8, res8;
  logic start2, m2, busy2, done2, c2, v2;
  logic [1:0] a2, b2, res2;
  logic start16, m16, busy16, done16, c16, v16;
  logic [15:0] a16, b16, res16;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q16[$];

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .mode(m8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(c8), .overflow(v8));
  serial_addsub #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rstx_n), .start(start2), .mode(m2), .a_in(a2), .b_in(b2),
    .busy(busy2), .done(done2), .result(res2), .cout(c2), .overflow(v2));
  serial_addsub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rstx_n), .start(start16), .mode(m16), .a_in(a16), .b_in(b16),
    .busy(busy16), .done(done16), .result(res16), .cout(c16), .overflow(v16));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, signed overflow from the true signed result.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, bit m, longint acc);
    exp_t e;
    longint full = longint'(1) << w;
    longint half = longint'(1) << (w - 1);
    longint mask = full - 1;
    longint ua = longint'(a) & mask;
    longint ub = longint'(b) & mask;
    longint sum, sa, sb, sr;
    sum = m ? (ua + ((~ub) & mask) + 1) : (ua + ub);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    sr = m ? (sa - sb) : (sa + sb);
    e.res = 32'(sum & mask);
    e.c   = ((sum >> w) & 1) != 0;
    e.v   = (sr > half - 1) || (sr < -half);
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  task automatic cmp(string nm, int w, exp_t e, logic [31:0] r, bit c, bit v, longint now);
    checks++;
    if (r !== e.res || c !== e.c || v !== e.v || now != e.acc + w) begin
      errors++;
      $display("FAIL %s: got result=%h cout=%0d ovf=%0d edge=%0d, expected result=%h cout=%0d ovf=%0d edge=%0d",
               nm, r, c, v, now, e.res, e.c, e.v, e.acc + w);
    end
  endtask

  task automatic unexpected(string nm);
    checks++;
    errors++;
    $display("FAIL %s: done with empty scoreboard at edge %0d", nm, cyc);
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst8_n === 1'b1) begin
      if (busy8 && done8) chk("w8_busy_and_done", 1, 0);
      if (done8) begin
        done_cnt8++;
        if (q8.size() == 0) unexpected("w8_done");
        else begin
          e = q8.pop_front();
          cmp("w8_op", 8, e, 32'(res8), c8, v8, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rstx_n === 1'b1) begin
      if (busy2 && done2) chk("w2_busy_and_done", 1, 0);
      if (done2) begin
        if (q2.size() == 0) unexpected("w2_done");
        else begin
          e = q2.pop_front();
          cmp("w2_op", 2, e, 32'(res2), c2, v2, cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rstx_n === 1'b1) begin
      if (busy16 && done16) chk("w16_busy_and_done", 1, 0);
      if (done16) begin
        if (q16.size() == 0) unexpected("w16_done");
        else begin
          e = q16.pop_front();
          cmp("w16_op", 16, e, 32'(res16), c16, v16, cyc);
        end
      end
    end
  end

  // Called at a falling edge; issues one op on the next rising edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit m);
    int g = 0;
    while (busy8 && g < 100) begin
      @(negedge clk);
      g++;
    end
    a8 = a; b8 = b; m8 = m; start8 = 1'b1;
    q8.push_back(model(8, 32'(a), 32'(b), m, cyc + 1));
    @(negedge clk);
    start8 = 1'b0;
    chk("w8_busy_after_accept", 32'(busy8), 1);
  endtask

  task automatic wait_idle8();
    int g = 0;
    #1;
    while (q8.size() != 0 && g < 50) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (q8.size() != 0) chk("w8_timeout", 32'(q8.size()), 0);
    @(negedge clk);
  endtask

  task automatic directed8();
    int g;
    int dc;
    issue8(8'd100, 8'd27, 1'b0);  wait_idle8();
    issue8(8'd100, 8'd28, 1'b0);  wait_idle8();
    issue8(8'hFF, 8'h01, 1'b0);   wait_idle8();
    issue8(8'h80, 8'h80, 1'b0);   wait_idle8();
    issue8(8'd5, 8'd7, 1'b1);     wait_idle8();
    issue8(8'h80, 8'h01, 1'b1);   wait_idle8();
    issue8(8'd9, 8'd9, 1'b1);     wait_idle8();
    // start held during RUN with fresh operands must be ignored.
    issue8(8'h11, 8'h22, 1'b0);
    g = 0;
    while (!done8 && g < 20) begin
      start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom_range(1));
      @(negedge clk);
      g++;
    end
    chk("w8_first_done_seen", 32'(done8), 1);
    // Back-to-back start while done is high.
    a8 = 8'h40; b8 = 8'h05; m8 = 1'b1; start8 = 1'b1;
    q8.push_back(model(8, 32'h40, 32'h05, 1'b1, cyc + 1));
    @(negedge clk);
    start8 = 1'b0;
    chk("w8_b2b_busy", 32'(busy8), 1);
    repeat (6) begin
      @(negedge clk);
      chk("w8_result_hold", 32'(res8), 32'h33);
    end
    wait_idle8();
    // Asynchronous reset three bits into an operation.
    issue8(8'd100, 8'd27, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst8_n = 1'b0;
    q8.delete();
    #1;
    chk("w8_rst_busy", 32'(busy8), 0);
    chk("w8_rst_done", 32'(done8), 0);
    chk("w8_rst_result", 32'(res8), 0);
    chk("w8_rst_cout", 32'(c8), 0);
    @(negedge clk);
    rst8_n = 1'b1;
    dc = done_cnt8;
    repeat (12) @(negedge clk);
    chk("w8_no_done_after_rst", 32'(done_cnt8), 32'(dc));
    issue8(8'd9, 8'd9, 1'b1);     wait_idle8();
  endtask

  initial begin : main
    start8 = 0; start2 = 0; start16 = 0;
    m8 = 0; m2 = 0; m16 = 0;
    a8 = 0; b8 = 0; a2 = 0; b2 = 0; a16 = 0; b16 = 0;
    rst8_n = 1'b1; rstx_n = 1'b1;
    #1;
    rst8_n = 1'b0; rstx_n = 1'b0;
    #2;
    chk("rst_w8_outputs", {busy8, done8, c8, v8, 20'd0, res8}, 0);
    chk("rst_w2_outputs", {busy2, done2, c2, v2, 26'd0, res2}, 0);
    chk("rst_w16_outputs", {busy16, done16, c16, v16, 12'd0, res16}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst8_n = 1'b1; rstx_n = 1'b1;
    fork
      directed8();
      begin : rnd2
        int n = 0;
        int g = 0;
        while (n < 1000 && g < 20000) begin
          g++;
          if (!busy2 && $urandom_range(3) != 0) begin
            a2 = 2'($urandom); b2 = 2'($urandom); m2 = 1'($urandom_range(1)); start2 = 1'b1;
            q2.push_back(model(2, 32'(a2), 32'(b2), m2, cyc + 1));
            n++;
          end else begin
            start2 = busy2 ? 1'($urandom_range(1)) : 1'b0;
            a2 = 2'($urandom); b2 = 2'($urandom); m2 = 1'($urandom_range(1));
          end
          @(negedge clk);
        end
        start2 = 1'b0;
        g = 0;
        #1;
        while (q2.size() != 0 && g < 50) begin
          @(negedge clk);
          #1;
          g++;
        end
        if (q2.size() != 0 || n != 1000) chk("w2_timeout", 32'(n), 1000);
      end
      begin : rnd16
        int n = 0;
        int g = 0;
        while (n < 1000 && g < 60000) begin
          g++;
          if (!busy16 && $urandom_range(3) != 0) begin
            a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'($urandom_range(1)); start16 = 1'b1;
            q16.push_back(model(16, 32'(a16), 32'(b16), m16, cyc + 1));
            n++;
          end else begin
            start16 = busy16 ? 1'($urandom_range(1)) : 1'b0;
            a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'($urandom_range(1));
          end
          @(negedge clk);
        end
        start16 = 1'b0;
        g = 0;
        #1;
        while (q16.size() != 0 && g < 50) begin
          @(negedge clk);
          #1;
          g++;
        end
        if (q16.size() != 0 || n != 1000) chk("w16_timeout", 32'(n), 1000);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
